// File: rtl/clkdiv_multi_pll.sv
// Multi-channel programmable clock-enable / divided-clock generator with a PLL-style lock flag.
// Each channel has a shadow config that is copied to the active set on apply, restarting all channels together.
module clkdiv_multi_pll #(
    parameter int NCH         = 4,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                                 clkin,
    input  logic                                 reset,
    input  logic                                 cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]                     cfg_div,
    input  logic [DIV_W-1:0]                     cfg_duty,
    input  logic [DIV_W-1:0]                     cfg_phase,
    input  logic                                 apply,
    input  logic [NCH-1:0]                       en,
    output logic [NCH-1:0]                       clk_out,
    output logic [NCH-1:0]                       ce,
    output logic                                 lock
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [DIV_W-1:0] ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] div,
                                                     input logic [DIV_W-1:0] phase);
        return (phase > div) ? div : phase;
    endfunction

    // High time is forced into 1..P-1 so the output always toggles (P==1 gives constant high).
    function automatic logic [DIV_W-1:0] eff_high(input logic [DIV_W-1:0] div,
                                                  input logic [DIV_W-1:0] duty);
        logic [DIV_W-1:0] d;
        d = (duty == ZERO) ? ONE : duty;
        if (div == ZERO) begin
            return ONE;
        end else begin
            return (d > div) ? div : d;
        end
    endfunction

    // Counter preload so that the first zero lands ph_eff cycles after the restart cycle.
    function automatic logic [DIV_W-1:0] start_count(input logic [DIV_W-1:0] div,
                                                     input logic [DIV_W-1:0] ph_eff);
        return (ph_eff == ZERO) ? ZERO : (div - ph_eff + ONE);
    endfunction

    logic [DIV_W-1:0] sh_div_r   [NCH];
    logic [DIV_W-1:0] sh_duty_r  [NCH];
    logic [DIV_W-1:0] sh_phase_r [NCH];
    logic [DIV_W-1:0] nx_div_s   [NCH];
    logic [DIV_W-1:0] nx_duty_s  [NCH];
    logic [DIV_W-1:0] nx_phase_s [NCH];
    logic [DIV_W-1:0] act_div_r  [NCH];
    logic [DIV_W-1:0] act_high_r [NCH];
    logic [DIV_W-1:0] cnt_r      [NCH];
    logic [LCK_W-1:0] lock_cnt_r;
    logic             lock_r;
    logic [NCH-1:0]   ce_r;
    logic [NCH-1:0]   clk_r;

    // Next shadow values; a write in the apply cycle is forwarded straight into the active set.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                nx_div_s[i]   = cfg_div;
                nx_duty_s[i]  = cfg_duty;
                nx_phase_s[i] = cfg_phase;
            end else begin
                nx_div_s[i]   = sh_div_r[i];
                nx_duty_s[i]  = sh_duty_r[i];
                nx_phase_s[i] = sh_phase_r[i];
            end
        end
    end

    // Shadow configuration registers.
    always_ff @(posedge clkin) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                sh_div_r[i]   <= ONE;
                sh_duty_r[i]  <= ONE;
                sh_phase_r[i] <= ZERO;
            end else begin
                sh_div_r[i]   <= nx_div_s[i];
                sh_duty_r[i]  <= nx_duty_s[i];
                sh_phase_r[i] <= nx_phase_s[i];
            end
        end
    end

    // Active configuration and free-running period counters; en never stops them.
    always_ff @(posedge clkin) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                act_div_r[i]  <= ONE;
                act_high_r[i] <= ONE;
                cnt_r[i]      <= ZERO;
            end else if (apply) begin
                act_div_r[i]  <= nx_div_s[i];
                act_high_r[i] <= eff_high(nx_div_s[i], nx_duty_s[i]);
                cnt_r[i]      <= start_count(nx_div_s[i], clamp_phase(nx_div_s[i], nx_phase_s[i]));
            end else if (cnt_r[i] == act_div_r[i]) begin
                cnt_r[i]      <= ZERO;
            end else begin
                cnt_r[i]      <= cnt_r[i] + ONE;
            end
        end
    end

    // Lock counter: lock rises LOCK_CYCLES cycles after each restart cycle.
    always_ff @(posedge clkin) begin
        if (reset || apply) begin
            lock_cnt_r <= {LCK_W{1'b0}};
            lock_r     <= 1'b0;
        end else if (!lock_r) begin
            lock_cnt_r <= lock_cnt_r + LCK_W'(1);
            lock_r     <= (lock_cnt_r == LCK_W'(LOCK_CYCLES - 1));
        end else begin
            lock_cnt_r <= lock_cnt_r;
            lock_r     <= lock_r;
        end
    end

    // Registered, gated outputs derived from the current counter state.
    always_ff @(posedge clkin) begin
        if (reset) begin
            ce_r  <= {NCH{1'b0}};
            clk_r <= {NCH{1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ce_r[i]  <= lock_r & en[i] & (cnt_r[i] == ZERO);
                clk_r[i] <= lock_r & en[i] & (cnt_r[i] < act_high_r[i]);
            end
        end
    end

    assign ce      = ce_r;
    assign clk_out = clk_r;
    assign lock    = lock_r;

endmodule

// File: tb/tb_clkdiv_multi_pll.sv
// Directed self-checking bench for clkdiv_multi_pll (five channels so an out-of-range cfg_ch is expressible).
// Output windows cover cycles 17..32 after each restart cycle; bit 15 of a pattern is cycle 17.
module tb_clkdiv_multi_pll;

    localparam int NCH = 5;

    logic           clkin     = 1'b0;
    logic           reset     = 1'b1;
    logic           cfg_we    = 1'b0;
    logic [2:0]     cfg_ch    = 3'd0;
    logic [7:0]     cfg_div   = 8'd0;
    logic [7:0]     cfg_duty  = 8'd0;
    logic [7:0]     cfg_phase = 8'd0;
    logic           apply     = 1'b0;
    logic [NCH-1:0] en        = 5'b11111;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] ce;
    logic           lock;

    int checks = 0;
    int errors = 0;

    logic [17:0]    lock_hist;
    logic [NCH-1:0] pre_out;
    logic [15:0]    obs_clk [NCH];
    logic [15:0]    obs_ce  [NCH];

    clkdiv_multi_pll #(.NCH(NCH), .DIV_W(8), .LOCK_CYCLES(16)) dut (
        .clkin     (clkin),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_duty  (cfg_duty),
        .cfg_phase (cfg_phase),
        .apply     (apply),
        .en        (en),
        .clk_out   (clk_out),
        .ce        (ce),
        .lock      (lock)
    );

    always #5 clkin = ~clkin;

    task automatic write_cfg(input logic [2:0] ch, input logic [7:0] d, input logic [7:0] du,
                             input logic [7:0] ph, input logic with_apply);
        @(negedge clkin);
        cfg_we = 1'b1; cfg_ch = ch; cfg_div = d; cfg_duty = du; cfg_phase = ph; apply = with_apply;
        @(negedge clkin);
        cfg_we = 1'b0; apply = 1'b0;
    endtask

    task automatic do_apply;
        @(negedge clkin);
        apply = 1'b1;
        @(negedge clkin);
        apply = 1'b0;
    endtask

    // Called at the negedge inside a restart cycle (k=0); records lock for k=0..17 and outputs.
    task automatic capture;
        lock_hist    = 18'd0;
        pre_out      = 5'd0;
        lock_hist[0] = lock;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clkin);
            if (k <= 17) lock_hist[k] = lock;
            if (k <= 16) pre_out = pre_out | clk_out | ce;
            if (k >= 17) begin
                for (int c = 0; c < NCH; c++) begin
                    obs_clk[c][32-k] = clk_out[c];
                    obs_ce[c][32-k]  = ce[c];
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [15:0] ec [NCH];
        logic [15:0] ee [NCH];
        ec = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};
        ee = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};
        reset = 1'b1;
        repeat (3) @(negedge clkin);
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL reset_lock got %b want 0", lock); end
        checks++; if (clk_out !== 5'b0) begin errors++; $display("FAIL reset_clk got %b want 00000", clk_out); end
        checks++; if (ce !== 5'b0) begin errors++; $display("FAIL reset_ce got %b want 00000", ce); end
        reset = 1'b0;
        capture();
        checks++; if (lock_hist !== 18'h30000) begin errors++; $display("FAIL reset_lock_time got %h want 30000", lock_hist); end
        checks++; if (pre_out !== 5'b0) begin errors++; $display("FAIL reset_prelock got %b want 00000", pre_out); end
        for (int c = 0; c < NCH; c++) begin
            checks++; if (obs_clk[c] !== ec[c]) begin errors++; $display("FAIL reset_clk%0d got %h want %h", c, obs_clk[c], ec[c]); end
            checks++; if (obs_ce[c] !== ee[c]) begin errors++; $display("FAIL reset_ce%0d got %h want %h", c, obs_ce[c], ee[c]); end
        end
    endtask

    task automatic test_phase;
        logic [15:0] ec [NCH];
        logic [15:0] ee [NCH];
        ec = '{16'hCCCC, 16'h6666, 16'hAAAA, 16'hAAAA, 16'hAAAA};
        ee = '{16'h8888, 16'h4444, 16'hAAAA, 16'hAAAA, 16'hAAAA};
        write_cfg(3'd0, 8'd3, 8'd2, 8'd0, 1'b0);
        write_cfg(3'd1, 8'd3, 8'd2, 8'd1, 1'b0);
        do_apply();
        capture();
        checks++; if (lock_hist !== 18'h30000) begin errors++; $display("FAIL phase_lock_time got %h want 30000", lock_hist); end
        checks++; if (pre_out !== 5'b0) begin errors++; $display("FAIL phase_prelock got %b want 00000", pre_out); end
        for (int c = 0; c < NCH; c++) begin
            checks++; if (obs_clk[c] !== ec[c]) begin errors++; $display("FAIL phase_clk%0d got %h want %h", c, obs_clk[c], ec[c]); end
            checks++; if (obs_ce[c] !== ee[c]) begin errors++; $display("FAIL phase_ce%0d got %h want %h", c, obs_ce[c], ee[c]); end
        end
    endtask

    task automatic test_duty_clamp;
        logic [15:0] ec [NCH];
        logic [15:0] ee [NCH];
        ec = '{16'hCCCC, 16'h6666, 16'h0842, 16'hEF7B, 16'hAAAA};
        ee = '{16'h8888, 16'h4444, 16'h0842, 16'h0842, 16'hAAAA};
        write_cfg(3'd2, 8'd4, 8'd0, 8'd0, 1'b0);
        write_cfg(3'd3, 8'd4, 8'd9, 8'd0, 1'b0);
        do_apply();
        capture();
        checks++; if (lock_hist !== 18'h30000) begin errors++; $display("FAIL duty_lock_time got %h want 30000", lock_hist); end
        for (int c = 0; c < NCH; c++) begin
            checks++; if (obs_clk[c] !== ec[c]) begin errors++; $display("FAIL duty_clk%0d got %h want %h", c, obs_clk[c], ec[c]); end
            checks++; if (obs_ce[c] !== ee[c]) begin errors++; $display("FAIL duty_ce%0d got %h want %h", c, obs_ce[c], ee[c]); end
        end
    endtask

    task automatic test_div0;
        logic [15:0] ec [NCH];
        logic [15:0] ee [NCH];
        ec = '{16'hFFFF, 16'h6666, 16'h0842, 16'hEF7B, 16'hAAAA};
        ee = '{16'hFFFF, 16'h4444, 16'h0842, 16'h0842, 16'hAAAA};
        write_cfg(3'd0, 8'd0, 8'd5, 8'd3, 1'b0);
        do_apply();
        capture();
        checks++; if (lock_hist !== 18'h30000) begin errors++; $display("FAIL div0_lock_time got %h want 30000", lock_hist); end
        for (int c = 0; c < NCH; c++) begin
            checks++; if (obs_clk[c] !== ec[c]) begin errors++; $display("FAIL div0_clk%0d got %h want %h", c, obs_clk[c], ec[c]); end
            checks++; if (obs_ce[c] !== ee[c]) begin errors++; $display("FAIL div0_ce%0d got %h want %h", c, obs_ce[c], ee[c]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ec [NCH];
        logic [15:0] ee [NCH];
        ec = '{16'hFFFF, 16'h6666, 16'h0842, 16'hEF7B, 16'hAAAA};
        ee = '{16'hFFFF, 16'h4444, 16'h0842, 16'h0842, 16'hAAAA};
        do_apply();
        for (int j = 0; j < 3; j++) begin
            @(negedge clkin);
            checks++;
            if ({lock, clk_out, ce} !== 11'b0) begin
                errors++; $display("FAIL b2b_gap%0d got %b want 0", j, {lock, clk_out, ce});
            end
        end
        do_apply();
        capture();
        checks++; if (lock_hist !== 18'h30000) begin errors++; $display("FAIL b2b_lock_time got %h want 30000", lock_hist); end
        checks++; if (pre_out !== 5'b0) begin errors++; $display("FAIL b2b_prelock got %b want 00000", pre_out); end
        for (int c = 0; c < NCH; c++) begin
            checks++; if (obs_clk[c] !== ec[c]) begin errors++; $display("FAIL b2b_clk%0d got %h want %h", c, obs_clk[c], ec[c]); end
            checks++; if (obs_ce[c] !== ee[c]) begin errors++; $display("FAIL b2b_ce%0d got %h want %h", c, obs_ce[c], ee[c]); end
        end
    endtask

    task automatic test_cfg_forward;
        logic [15:0] ec [NCH];
        logic [15:0] ee [NCH];
        ec = '{16'hFFFF, 16'h38E3, 16'h0842, 16'hEF7B, 16'hAAAA};
        ee = '{16'hFFFF, 16'h2082, 16'h0842, 16'h0842, 16'hAAAA};
        write_cfg(3'd7, 8'd0, 8'd0, 8'd0, 1'b0);
        write_cfg(3'd5, 8'd0, 8'd0, 8'd0, 1'b0);
        write_cfg(3'd1, 8'd5, 8'd3, 8'd0, 1'b1);
        capture();
        checks++; if (lock_hist !== 18'h30000) begin errors++; $display("FAIL cfg_lock_time got %h want 30000", lock_hist); end
        for (int c = 0; c < NCH; c++) begin
            checks++; if (obs_clk[c] !== ec[c]) begin errors++; $display("FAIL cfg_clk%0d got %h want %h", c, obs_clk[c], ec[c]); end
            checks++; if (obs_ce[c] !== ee[c]) begin errors++; $display("FAIL cfg_ce%0d got %h want %h", c, obs_ce[c], ee[c]); end
        end
    endtask

    task automatic test_en_gap;
        int   m;
        logic ec0;
        logic ee0;
        logic g;
        write_cfg(3'd0, 8'd5, 8'd3, 8'd0, 1'b0);
        do_apply();
        capture();
        for (int c = 0; c < 2; c++) begin
            checks++; if (obs_clk[c] !== 16'h38E3) begin errors++; $display("FAIL en_clk%0d got %h want 38e3", c, obs_clk[c]); end
            checks++; if (obs_ce[c] !== 16'h2082) begin errors++; $display("FAIL en_ce%0d got %h want 2082", c, obs_ce[c]); end
        end
        @(negedge clkin);
        en = 5'b11101;
        for (int k = 34; k <= 52; k++) begin
            @(negedge clkin);
            m   = (k - 1) % 6;
            ec0 = (m < 3);
            ee0 = (m == 0);
            g   = (k > 40);
            checks++;
            if ({clk_out[0], ce[0]} !== {ec0, ee0}) begin
                errors++; $display("FAIL en_ch0 k=%0d got %b%b want %b%b", k, clk_out[0], ce[0], ec0, ee0);
            end
            checks++;
            if ({clk_out[1], ce[1]} !== {ec0 & g, ee0 & g}) begin
                errors++; $display("FAIL en_ch1 k=%0d got %b%b want %b%b", k, clk_out[1], ce[1], ec0 & g, ee0 & g);
            end
            if (k == 40) en = 5'b11111;
        end
    endtask

    initial begin
        test_reset();
        test_phase();
        test_duty_clamp();
        test_div0();
        test_back_to_back();
        test_cfg_forward();
        test_en_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
